// File: rtl/t03_bus_pkg.sv
// t03_bus_pkg: shared types and constants for the fetch/data Wishbone arbiter.
package t03_bus_pkg;
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, CAPTURE, DONE} arb_state_t;
    typedef enum logic {OWN_FETCH, OWN_DATA} owner_t;
    localparam logic [3:0] FETCH_SEL_DEF = 4'b1111;
endpackage

// File: rtl/t03_rr_pick2.sv
// t03_rr_pick2: two-way round-robin picker; on a tie the port not granted last wins.
module t03_rr_pick2
    import t03_bus_pkg::*;
(
    input  logic   fetch_req_i,
    input  logic   data_req_i,
    input  owner_t last_grant_i,
    output logic   valid_o,
    output owner_t owner_o
);
    assign valid_o = fetch_req_i | data_req_i;
    assign owner_o = (fetch_req_i & data_req_i) ? ((last_grant_i == OWN_DATA) ? OWN_FETCH : OWN_DATA)
                                                : (data_req_i ? OWN_DATA : OWN_FETCH);
endmodule

// File: rtl/t03_bus_arbiter.sv
// t03_bus_arbiter: shares one Wishbone manager between the fetch port and the data port,
// issuing one latched request at a time and returning read data with a done pulse.
module t03_bus_arbiter
    import t03_bus_pkg::*;
#(
    parameter logic       RESET_LAST_GRANT = 1'b1,
    parameter logic [3:0] FETCH_SEL        = FETCH_SEL_DEF
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        i_read,
    input  logic [31:0] i_adr,
    output logic [31:0] i_rdata,
    output logic        i_done,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_adr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_sel,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic        mgr_read,
    output logic        mgr_write,
    output logic [31:0] mgr_adr,
    output logic [31:0] mgr_wdata,
    output logic [3:0]  mgr_sel,
    input  logic [31:0] mgr_rdata,
    input  logic        mgr_busy,
    input  logic        mgr_ack
);
    arb_state_t  state_q, state_d;
    owner_t      last_q, last_d, owner_q, owner_d, gnt_own;
    logic [31:0] adr_q, adr_d, wdata_q, wdata_d, i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
    logic [3:0]  sel_q, sel_d;
    logic        we_q, we_d, gnt_v, take_fetch;

    t03_rr_pick2 u_pick (
        .fetch_req_i (i_read),
        .data_req_i  (d_read | d_write),
        .last_grant_i(last_q),
        .valid_o     (gnt_v),
        .owner_o     (gnt_own)
    );

    assign take_fetch = (gnt_own == OWN_FETCH);

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        owner_d   = owner_q;
        adr_d     = adr_q;
        wdata_d   = wdata_q;
        sel_d     = sel_q;
        we_d      = we_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        case (state_q)
            IDLE: if (gnt_v && !mgr_busy) begin
                state_d = ISSUE;
                owner_d = gnt_own;
                last_d  = gnt_own;
                adr_d   = take_fetch ? i_adr : d_adr;
                sel_d   = take_fetch ? FETCH_SEL : d_sel;
                we_d    = take_fetch ? 1'b0 : d_write;
                wdata_d = take_fetch ? 32'd0 : d_wdata;
            end
            ISSUE:    state_d = WAIT_ACK;
            WAIT_ACK: state_d = mgr_ack ? CAPTURE : WAIT_ACK;
            CAPTURE: begin
                state_d = DONE;
                // Manager read data is registered, so it is valid here, one cycle after ack
                if (!we_q && owner_q == OWN_FETCH) i_rdata_d = mgr_rdata;
                if (!we_q && owner_q == OWN_DATA) d_rdata_d = mgr_rdata;
            end
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= IDLE;
            last_q    <= owner_t'(RESET_LAST_GRANT);
            owner_q   <= OWN_FETCH;
            adr_q     <= '0;
            wdata_q   <= '0;
            sel_q     <= '0;
            we_q      <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            owner_q   <= owner_d;
            adr_q     <= adr_d;
            wdata_q   <= wdata_d;
            sel_q     <= sel_d;
            we_q      <= we_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign mgr_read  = (state_q == ISSUE) && !we_q;
    assign mgr_write = (state_q == ISSUE) && we_q;
    assign mgr_adr   = adr_q;
    assign mgr_wdata = wdata_q;
    assign mgr_sel   = sel_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign i_done    = (state_q == DONE) && (owner_q == OWN_FETCH);
    assign d_done    = (state_q == DONE) && (owner_q == OWN_DATA);
endmodule

// File: tb/tb_t03_bus_arbiter.sv
// tb_t03_bus_arbiter: directed cycle-exact checks of the fetch/data bus arbiter.
module tb_t03_bus_arbiter;
    logic        CLK = 1'b0, nRST = 1'b0;
    logic        i_read = 1'b0, d_read = 1'b0, d_write = 1'b0;
    logic [31:0] i_adr = '0, d_adr = '0, d_wdata = '0, mgr_rdata = '0;
    logic [3:0]  d_sel = '0;
    logic        mgr_busy = 1'b0, mgr_ack = 1'b0;
    logic [31:0] i_rdata, d_rdata, mgr_adr, mgr_wdata;
    logic [3:0]  mgr_sel;
    logic        i_done, d_done, mgr_read, mgr_write;
    int          errors = 0, checks = 0, issues = 0;

    t03_bus_arbiter dut (
        .CLK(CLK), .nRST(nRST),
        .i_read(i_read), .i_adr(i_adr), .i_rdata(i_rdata), .i_done(i_done),
        .d_read(d_read), .d_write(d_write), .d_adr(d_adr), .d_wdata(d_wdata), .d_sel(d_sel),
        .d_rdata(d_rdata), .d_done(d_done),
        .mgr_read(mgr_read), .mgr_write(mgr_write), .mgr_adr(mgr_adr), .mgr_wdata(mgr_wdata),
        .mgr_sel(mgr_sel), .mgr_rdata(mgr_rdata), .mgr_busy(mgr_busy), .mgr_ack(mgr_ack)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) if (mgr_read || mgr_write) issues <= issues + 1;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called in the ISSUE cycle; ack comes dly cycles later, data the cycle after, returns in DONE.
    task automatic serve(input logic [31:0] rd, input int dly);
        for (int d = 1; d <= dly; d++) begin
            tick();
            if (d == dly) mgr_ack = 1'b1;
        end
        tick();
        mgr_ack   = 1'b0;
        mgr_rdata = rd;
        tick();
        mgr_rdata = 32'h0;
    endtask

    initial begin
        repeat (2) tick();
        chk("rst_mgr_read", mgr_read, 0);
        chk("rst_mgr_write", mgr_write, 0);
        chk("rst_mgr_adr", mgr_adr, 0);
        chk("rst_mgr_sel", mgr_sel, 0);
        chk("rst_dones", {i_done, d_done}, 0);
        chk("rst_rdata", i_rdata | d_rdata, 0);
        nRST = 1'b1;

        // Fetch alone, ack three cycles after issue
        i_read = 1'b1;
        i_adr  = 32'h3300_0010;
        chk("t1_c0_no_issue", mgr_read, 0);
        tick();
        chk("t1_mgr_read", mgr_read, 1);
        chk("t1_mgr_write", mgr_write, 0);
        chk("t1_mgr_adr", mgr_adr, 32'h3300_0010);
        chk("t1_mgr_sel", mgr_sel, 4'hF);
        serve(32'hDEAD_BEEF, 3);
        chk("t1_i_done", i_done, 1);
        chk("t1_d_done", d_done, 0);
        chk("t1_i_rdata", i_rdata, 32'hDEAD_BEEF);
        i_read = 1'b0;
        tick();
        chk("t1_i_done_low", i_done, 0);
        chk("t1_i_rdata_hold", i_rdata, 32'hDEAD_BEEF);
        chk("t1_issues", issues, 1);

        // Data write
        d_write = 1'b1;
        d_adr   = 32'h3300_0020;
        d_wdata = 32'h1234_5678;
        d_sel   = 4'b0011;
        tick();
        chk("t2_mgr_write", mgr_write, 1);
        chk("t2_mgr_read", mgr_read, 0);
        chk("t2_mgr_adr", mgr_adr, 32'h3300_0020);
        chk("t2_mgr_wdata", mgr_wdata, 32'h1234_5678);
        chk("t2_mgr_sel", mgr_sel, 4'b0011);
        serve(32'hBAD0_BAD0, 2);
        chk("t2_d_done", d_done, 1);
        chk("t2_i_done", i_done, 0);
        chk("t2_d_rdata_kept", d_rdata, 0);
        d_write = 1'b0;
        tick();
        chk("t2_d_done_low", d_done, 0);
        chk("t2_issues", issues, 2);

        // Ties after a fresh reset alternate F, D, F, D
        nRST = 1'b0;
        tick();
        nRST   = 1'b1;
        i_read = 1'b1;
        d_read = 1'b1;
        i_adr  = 32'h0000_1000;
        d_adr  = 32'h0000_2000;
        for (int n = 0; n < 4; n++) begin
            tick();
            chk($sformatf("t3_adr%0d", n), mgr_adr, (n % 2 == 0) ? 32'h0000_1000 : 32'h0000_2000);
            chk($sformatf("t3_read%0d", n), mgr_read, 1);
            serve(32'hA000_0000 + 32'(n), 1);
            chk($sformatf("t3_i_done%0d", n), i_done, (n % 2 == 0) ? 1 : 0);
            chk($sformatf("t3_d_done%0d", n), d_done, (n % 2 == 0) ? 0 : 1);
            chk($sformatf("t3_rdata%0d", n), (n % 2 == 0) ? i_rdata : d_rdata, 32'hA000_0000 + 32'(n));
            if (n == 3) begin
                i_read = 1'b0;
                d_read = 1'b0;
            end
            tick();
        end
        chk("t3_issues", issues, 6);

        // Manager busy for four cycles holds off the issue
        mgr_busy = 1'b1;
        d_read   = 1'b1;
        d_adr    = 32'h0000_3000;
        for (int n = 0; n < 4; n++) begin
            tick();
            chk($sformatf("t4_busy_hold%0d", n), {mgr_read, mgr_write}, 0);
        end
        mgr_busy = 1'b0;
        tick();
        chk("t4_mgr_read", mgr_read, 1);
        chk("t4_mgr_adr", mgr_adr, 32'h0000_3000);
        serve(32'h5555_AAAA, 2);
        chk("t4_d_done", d_done, 1);
        chk("t4_d_rdata", d_rdata, 32'h5555_AAAA);
        d_read = 1'b0;
        tick();
        chk("t4_issues", issues, 7);

        // Read and write together is a write
        d_read  = 1'b1;
        d_write = 1'b1;
        d_adr   = 32'h0000_4000;
        d_wdata = 32'hCAFE_F00D;
        d_sel   = 4'hC;
        tick();
        chk("t5_mgr_write", mgr_write, 1);
        chk("t5_mgr_read", mgr_read, 0);
        chk("t5_mgr_wdata", mgr_wdata, 32'hCAFE_F00D);
        chk("t5_mgr_sel", mgr_sel, 4'hC);
        serve(32'h0BAD_0BAD, 1);
        chk("t5_d_done", d_done, 1);
        chk("t5_d_rdata_kept", d_rdata, 32'h5555_AAAA);
        d_read  = 1'b0;
        d_write = 1'b0;
        tick();

        // Fetch dropped after grant still completes; address changes are ignored
        i_read = 1'b1;
        i_adr  = 32'h0000_5000;
        tick();
        chk("t5_fetch_issue", mgr_read, 1);
        i_read = 1'b0;
        i_adr  = 32'hFFFF_FFFF;
        serve(32'h7777_0001, 2);
        chk("t5_i_done", i_done, 1);
        chk("t5_i_rdata", i_rdata, 32'h7777_0001);
        chk("t5_adr_latched", mgr_adr, 32'h0000_5000);
        tick();

        // Reset in WAIT_ACK clears everything immediately
        d_read = 1'b1;
        d_adr  = 32'h0000_6000;
        tick();
        tick();
        nRST = 1'b0;
        #1;
        chk("t6_rst_mgr", {mgr_read, mgr_write}, 0);
        chk("t6_rst_adr", mgr_adr, 0);
        chk("t6_rst_done", {i_done, d_done}, 0);
        chk("t6_rst_i_rdata", i_rdata, 0);
        tick();
        d_adr = 32'h0000_7000;
        tick();
        nRST = 1'b1;
        tick();
        chk("t6_mgr_read", mgr_read, 1);
        chk("t6_mgr_adr", mgr_adr, 32'h0000_7000);
        serve(32'h1357_9BDF, 2);
        chk("t6_d_done", d_done, 1);
        chk("t6_d_rdata", d_rdata, 32'h1357_9BDF);
        d_read = 1'b0;
        tick();
        chk("t6_d_done_low", d_done, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
